// File: rtl/cmd_tx_arbiter.sv
// cmd_tx_arbiter
//   Shares one command transmitter between NUM_REQ independent requesters.
//   The arbiter is round-robin and keeps one command outstanding at a time.
//   Each command has a completion timeout.
//   A minimum idle gap is enforced after every command.
//
// Ports
//   clk       system clock
//   rst_n     asynchronous active-low reset
//   req_vld   level request per requester, held until its req_ack/req_err
//   req_type  packed command types, requester i at [i*TYPE_W +: TYPE_W]
//   req_ack   one-cycle pulse: granted requester's command completed
//   req_err   one-cycle pulse: granted requester's command timed out
//   cmd_tx    one-cycle start pulse to the command engine
//   cmd_type  type of the current command, latched at grant
//   cmd_done  one-cycle completion pulse from the command engine
//   busy      high whenever the arbiter is not idle
//   grant_id  index of the current or most recently granted requester
module cmd_tx_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int TYPE_W  = 2,
  parameter int TIMEOUT = 1023,
  parameter int GAP     = 10,
  localparam int ID_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_vld,
  input  logic [NUM_REQ*TYPE_W-1:0] req_type,
  output logic [NUM_REQ-1:0]        req_ack,
  output logic [NUM_REQ-1:0]        req_err,
  output logic                      cmd_tx,
  output logic [TYPE_W-1:0]         cmd_type,
  input  logic                      cmd_done,
  output logic                      busy,
  output logic [ID_W-1:0]           grant_id
);

  localparam int TIMER_W = 16;
  localparam int GAP_W   = 8;
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT - 1);
  localparam logic [GAP_W-1:0]   GAP_LAST   = GAP_W'((GAP > 0) ? GAP - 1 : 0);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT_DONE,
    S_GAP
  } state_t;

  state_t               state;
  state_t               state_next;
  logic [ID_W-1:0]      last;
  logic [TIMER_W-1:0]   timer;
  logic [GAP_W-1:0]     gap_cnt;

  logic                 win_found;
  logic [ID_W-1:0]      win_id;
  logic [ID_W:0]        cand;
  logic [TYPE_W-1:0]    win_type;
  logic [NUM_REQ-1:0]   grant_oh;
  logic                 done_hit;
  logic                 tout_hit;
  logic                 gap_end;

  // Round-robin search: start just above the last winner and wrap.
  // The first requester found with req_vld set wins.
  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    cand      = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = {1'b0, last} + (ID_W+1)'(k);
      if (cand >= (ID_W+1)'(NUM_REQ)) begin
        cand = cand - (ID_W+1)'(NUM_REQ);
      end
      if (!win_found && req_vld[cand[ID_W-1:0]]) begin
        win_found = 1'b1;
        win_id    = cand[ID_W-1:0];
      end
    end
  end

  // Select the winner's command type from the packed type bus.
  always_comb begin
    win_type = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (win_id == ID_W'(i)) begin
        win_type = req_type[i*TYPE_W +: TYPE_W];
      end
    end
  end

  assign grant_oh = NUM_REQ'(1) << grant_id;

  // If cmd_done and the timeout land in the same cycle, done wins.
  assign done_hit = (state == S_WAIT_DONE) && cmd_done;
  assign tout_hit = (state == S_WAIT_DONE) && !cmd_done && (timer == TIMER_LAST);
  assign gap_end  = (state == S_GAP) && (gap_cnt == GAP_LAST);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic.
  // With GAP=0 the GAP state is skipped so the arbiter is idle right after a command ends.
  always_comb begin
    state_next = state;
    unique case (state)
      S_IDLE: begin
        if (win_found) begin
          state_next = S_ISSUE;
        end
      end
      S_ISSUE: begin
        state_next = S_WAIT_DONE;
      end
      S_WAIT_DONE: begin
        if (done_hit || tout_hit) begin
          state_next = (GAP == 0) ? S_IDLE : S_GAP;
        end
      end
      S_GAP: begin
        if (gap_end) begin
          state_next = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Registered outputs and datapath.
  // cmd_tx and busy are registered from the next state.
  // They therefore line up exactly with ISSUE and non-IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_tx   <= 1'b0;
      busy     <= 1'b0;
      req_ack  <= '0;
      req_err  <= '0;
      grant_id <= '0;
      cmd_type <= '0;
      last     <= ID_W'(NUM_REQ - 1);
      timer    <= '0;
      gap_cnt  <= '0;
    end else begin
      cmd_tx  <= (state_next == S_ISSUE);
      busy    <= (state_next != S_IDLE);
      req_ack <= done_hit ? grant_oh : '0;
      req_err <= tout_hit ? grant_oh : '0;

      if (state == S_IDLE && win_found) begin
        grant_id <= win_id;
        cmd_type <= win_type;
        last     <= win_id;
      end

      if (state == S_ISSUE) begin
        timer <= '0;
      end else if (state == S_WAIT_DONE) begin
        timer <= timer + TIMER_W'(1);
      end

      if (state == S_GAP) begin
        gap_cnt <= gap_cnt + GAP_W'(1);
      end else begin
        gap_cnt <= '0;
      end
    end
  end

endmodule
